// File: rtl/mmio_router_pkg.sv
// Shared types and constants for the MMIO router and its slot decoder.
package mmio_router_pkg;

    // Slot access sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Data returned to the CPU when a slot never acknowledges.
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    // Default address map.
    localparam logic [19:0] MMIO_PAGE_DEF  = 20'haaaaa;
    localparam logic [3:0]  SLOT_FIRST_DEF = 4'd4;
    localparam int          NSLOT_DEF      = 4;
    localparam logic [31:0] MEM_OFFSET_DEF = 32'h2000;
    localparam int          TIMEOUT_DEF    = 15;

    // Index width for n items, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmio_router_slot_decode.sv
// One-hot MMIO slot decoder: flags the MMIO page and picks the slot from addr[11:8].
module mmio_slot_decode
    import mmio_router_pkg::*;
#(
    parameter int          NSLOT      = NSLOT_DEF,
    parameter logic [19:0] MMIO_PAGE  = MMIO_PAGE_DEF,
    parameter logic [3:0]  SLOT_FIRST = SLOT_FIRST_DEF,
    parameter int          IW         = idx_w(NSLOT)
) (
    input  logic [31:0]      addr,
    output logic             mmio,
    output logic             hit,
    output logic [NSLOT-1:0] sel,
    output logic [IW-1:0]    idx
);

    // Page compare plus per-slot nibble compare; at most one slot can match.
    always_comb begin
        mmio = (addr[31:12] == MMIO_PAGE);
        hit  = 1'b0;
        sel  = '0;
        idx  = '0;
        for (int k = 0; k < NSLOT; k++) begin
            if (mmio && (int'(addr[11:8]) == int'(SLOT_FIRST) + k)) begin
                sel[k] = 1'b1;
                hit    = 1'b1;
                idx    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/mmio_router.sv
// CPU address router: plain memory accesses go straight to the memory port
// (shared with an aux master), MMIO slot accesses stall the CPU until the
// slot acks or a timeout forces completion with a marker value.
module mmio_router
    import mmio_router_pkg::*;
#(
    parameter int          NSLOT      = NSLOT_DEF,
    parameter logic [19:0] MMIO_PAGE  = MMIO_PAGE_DEF,
    parameter logic [3:0]  SLOT_FIRST = SLOT_FIRST_DEF,
    parameter logic [31:0] MEM_OFFSET = MEM_OFFSET_DEF,
    parameter int          TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    input  logic [3:0]            cpu_be,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_hold,
    input  logic                  aux_req,
    input  logic                  aux_we,
    input  logic [31:0]           aux_addr,
    input  logic [31:0]           aux_wdata,
    output logic                  aux_gnt,
    output logic [31:0]           aux_rdata,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic [NSLOT-1:0]      slot_sel,
    output logic                  slot_we,
    output logic [7:0]            slot_addr,
    output logic [31:0]           slot_wdata,
    input  logic [NSLOT*32-1:0]   slot_rdata,
    input  logic [NSLOT-1:0]      slot_ack,
    output logic                  err
);

    localparam int IW = idx_w(NSLOT);
    localparam int CW = $clog2(TIMEOUT + 2);

    state_e          state_q, state_d;
    logic [IW-1:0]   slot_q, slot_d;
    logic            we_q, we_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     data_q, data_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            ret_mem_q, ret_mem_d;
    logic            ret_aux_q, ret_aux_d;

    logic             dec_mmio;
    logic             dec_hit;
    logic [NSLOT-1:0] dec_sel;
    logic [IW-1:0]    dec_idx;

    logic             cpu_mem;
    logic             aux_win;
    logic             issue;
    logic             ack_new, ack_cur;
    logic [31:0]      rd_new, rd_cur;
    logic [NSLOT-1:0] cur_sel;

    mmio_slot_decode #(
        .NSLOT      (NSLOT),
        .MMIO_PAGE  (MMIO_PAGE),
        .SLOT_FIRST (SLOT_FIRST),
        .IW         (IW)
    ) u_dec (
        .addr (cpu_addr),
        .mmio (dec_mmio),
        .hit  (dec_hit),
        .sel  (dec_sel),
        .idx  (dec_idx)
    );

    // Request classification; the CPU request is ignored during RESP.
    always_comb begin
        cpu_mem = cpu_req && !dec_mmio && (state_q != ST_RESP);
        aux_win = aux_req && !cpu_mem;
        issue   = (state_q == ST_IDLE) && cpu_req && dec_hit;
    end

    // Ack/data muxes for the newly decoded slot and the latched slot.
    always_comb begin
        ack_new = 1'b0;
        ack_cur = 1'b0;
        rd_new  = '0;
        rd_cur  = '0;
        cur_sel = '0;
        for (int k = 0; k < NSLOT; k++) begin
            if (dec_idx == IW'(k)) begin
                ack_new = slot_ack[k];
                rd_new  = slot_rdata[k*32 +: 32];
            end
            if (slot_q == IW'(k)) begin
                ack_cur    = slot_ack[k];
                rd_cur     = slot_rdata[k*32 +: 32];
                cur_sel[k] = 1'b1;
            end
        end
    end

    // Next-state logic: slot sequencer, timeout counter, read-return steering.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ret_mem_d = cpu_mem && !cpu_we;
        ret_aux_d = aux_win && !aux_we;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (issue) begin
                    slot_d  = dec_idx;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    cnt_d   = CW'(1);
                    if (ack_new) begin
                        data_d  = rd_new;
                        state_d = ST_RESP;
                    end else if (TIMEOUT <= 1) begin
                        data_d  = TIMEOUT_DATA;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // The issue cycle counts as the first held cycle.
                cnt_d = cnt_q + CW'(1);
                if (ack_cur) begin
                    data_d  = rd_cur;
                    state_d = ST_RESP;
                end else if (cnt_d >= CW'(TIMEOUT)) begin
                    data_d  = TIMEOUT_DATA;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            slot_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            ret_mem_q <= 1'b0;
            ret_aux_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ret_mem_q <= ret_mem_d;
            ret_aux_q <= ret_aux_d;
        end
    end

    // Memory port: CPU memory access first, otherwise the aux master.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        aux_gnt   = 1'b0;
        if (!rst) begin
            if (cpu_mem) begin
                mem_en    = 1'b1;
                mem_we    = cpu_we ? cpu_be : 4'b0000;
                mem_addr  = cpu_addr - MEM_OFFSET;
                mem_wdata = cpu_wdata;
            end else if (aux_win) begin
                aux_gnt   = 1'b1;
                mem_en    = 1'b1;
                mem_we    = aux_we ? 4'b1111 : 4'b0000;
                mem_addr  = aux_addr - MEM_OFFSET;
                mem_wdata = aux_wdata;
            end
        end
    end

    // Slot port: decoded select on the issue cycle, latched select while waiting.
    always_comb begin
        slot_sel   = '0;
        slot_we    = 1'b0;
        slot_addr  = '0;
        slot_wdata = '0;
        if (!rst) begin
            slot_addr = cpu_addr[7:0];
            if (issue) begin
                slot_sel   = dec_sel;
                slot_we    = cpu_we;
                slot_wdata = cpu_wdata;
            end else if (state_q == ST_WAIT) begin
                slot_sel   = cur_sel;
                slot_we    = we_q;
                slot_wdata = wdata_q;
            end
        end
    end

    // CPU/aux return path and status.
    always_comb begin
        cpu_hold  = 1'b0;
        cpu_rdata = '0;
        aux_rdata = '0;
        err       = 1'b0;
        if (!rst) begin
            cpu_hold = issue || (state_q == ST_WAIT);
            if (state_q == ST_RESP) begin
                cpu_rdata = data_q;
            end else if (ret_mem_q) begin
                cpu_rdata = mem_rdata;
            end
            if (ret_aux_q) begin
                aux_rdata = mem_rdata;
            end
            err = err_q;
        end
    end

endmodule
